// File: rtl/escalonador_rr_if.sv
// Retire/fetch-redirect bundle between processor and round-robin scheduler.
// master = processor (retire info out, PC load in); slave = scheduler.
interface escalonador_rr_if;
  logic        instr_retire;
  logic [31:0] pc_atual;
  logic        proc_end;
  logic        switch_req;
  logic        pc_load_valid;
  logic [31:0] pc_load_val;

  modport master (
    output instr_retire, pc_atual, proc_end,
    input  switch_req, pc_load_valid, pc_load_val
  );

  modport slave (
    input  instr_retire, pc_atual, proc_end,
    output switch_req, pc_load_valid, pc_load_val
  );
endinterface

// File: rtl/escalonador_rr.sv
// Round-robin process scheduler: counts retires per slice, saves PC, picks next.
// Ports: clock/reset, enable, mask_load/mask_data, cpu (slave bundle), processo_atual, all_done.
module escalonador_rr #(
  parameter int NPROC   = 10,
  parameter int REGION  = 300,
  parameter int QUANTUM = 16,
  parameter int QW      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mask_load,
  input  logic [NPROC-1:0] mask_data,
  escalonador_rr_if.slave  cpu,
  output logic [3:0]       processo_atual,
  output logic             all_done
);

  typedef enum logic [2:0] {
    IDLE, SELECT, LOAD, RUN, SAVE, DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [NPROC-1:0] ready;
  logic [QW-1:0]    cnt;
  logic [3:0]       next_id;
  logic [31:0]      last_pc;
  logic [31:0]      pc_tab [0:NPROC];

  // ready bits re-indexed by process id (id 0 never ready)
  logic [NPROC:0]   rdy_id;
  logic [3:0]       pick;
  logic             found;
  logic [4:0]       cand;
  logic             q_end;

  assign rdy_id = {ready, 1'b0};
  assign q_end  = (cnt == QW'(QUANTUM - 1));

  // first ready id after the running one, wrapping NPROC -> 1
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NPROC; k++) begin
      cand = {1'b0, processo_atual} + 5'(k);
      if (cand > 5'(NPROC))
        cand = cand - 5'(NPROC);
      if (!found && rdy_id[cand[3:0]]) begin
        found = 1'b1;
        pick  = cand[3:0];
      end
    end
  end

  always_comb begin
    state_nx          = state;
    cpu.switch_req    = 1'b0;
    cpu.pc_load_valid = 1'b0;
    cpu.pc_load_val   = '0;
    all_done          = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|ready))
          state_nx = SELECT;
      end
      SELECT: begin
        cpu.switch_req = 1'b1;
        state_nx       = found ? LOAD : DONE;
      end
      LOAD: begin
        cpu.switch_req    = 1'b1;
        cpu.pc_load_valid = 1'b1;
        cpu.pc_load_val   = pc_tab[next_id];
        state_nx          = RUN;
      end
      RUN: begin
        if (!enable)
          state_nx = SAVE;
        else if (cpu.instr_retire &&
                 (cpu.proc_end || q_end))
          state_nx = SAVE;
      end
      SAVE: begin
        cpu.switch_req = 1'b1;
        state_nx       = enable ? SELECT : IDLE;
      end
      DONE: begin
        cpu.switch_req    = 1'b1;
        cpu.pc_load_valid = 1'b1;
        all_done          = 1'b1;
        state_nx          = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ready          <= '0;
      cnt            <= '0;
      next_id        <= '0;
      last_pc        <= '0;
      processo_atual <= '0;
      for (int i = 0; i <= NPROC; i++)
        pc_tab[4'(i)] <= 32'(i * REGION);
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (mask_load)
            ready <= mask_data;
        end
        SELECT: begin
          if (found)
            next_id <= pick;
        end
        LOAD: begin
          processo_atual <= next_id;
          cnt            <= '0;
          // saving with no retire restores the slice's entry PC
          last_pc        <= pc_tab[next_id] - 32'd1;
        end
        RUN: begin
          if (cpu.instr_retire) begin
            cnt     <= cnt + QW'(1);
            last_pc <= cpu.pc_atual;
            if (cpu.proc_end)
              ready[processo_atual - 4'd1] <= 1'b0;
          end
        end
        SAVE: begin
          pc_tab[processo_atual] <= last_pc + 32'd1;
        end
        DONE: begin
          processo_atual <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_rr.sv
// Bench for escalonador_rr: event-level scheduler model plus directed scenarios.
// Compares every cycle against the model and pins key values with literals.
module tb_escalonador_rr;
  localparam int NP = 10;
  localparam int RG = 300;
  localparam int QT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          mask_load = 1'b0;
  logic [NP-1:0] mask_data = '0;
  logic [3:0]    processo_atual;
  logic          all_done;

  escalonador_rr_if bus ();

  escalonador_rr #(
    .NPROC(NP), .REGION(RG),
    .QUANTUM(QT), .QW(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .mask_load(mask_load),
    .mask_data(mask_data),
    .cpu(bus.slave),
    .processo_atual(processo_atual),
    .all_done(all_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        sw;
    logic        plv;
    logic [31:0] val;
    logic [3:0]  pr;
    logic        ad;
  } frame_t;

  logic [NP-1:0] m_mask;
  logic [31:0]   m_tab [$];
  logic [3:0]    m_proc;
  int            m_cnt;
  logic [31:0]   m_resume;
  bit            m_run;
  bit            go;
  bit            trig;
  frame_t        q [$];
  frame_t        cur;
  bit            chk_on = 0;

  function automatic frame_t fr(bit sw, bit plv,
                                logic [31:0] v,
                                logic [3:0] p, bit ad);
    frame_t f;
    f.sw = sw; f.plv = plv; f.val = v;
    f.pr = p;  f.ad = ad;
    return f;
  endfunction

  task automatic m_init();
    m_mask = '0;
    m_tab.delete();
    for (int i = 0; i <= NP; i++)
      m_tab.push_back(32'(i * RG));
    m_proc = '0;
    m_cnt = 0;
    m_resume = '0;
    m_run = 0;
    q.delete();
    cur = fr(0, 0, 0, 0, 0);
  endtask

  function automatic int m_next();
    int id;
    for (int k = 1; k <= NP; k++) begin
      id = (int'(m_proc) + k - 1) % NP + 1;
      if (((m_mask >> (id - 1)) & NP'(1)) != 0)
        return id;
    end
    return 0;
  endfunction

  // queue the SELECT frame, then LOAD or DONE
  task automatic m_pick();
    int n;
    q.push_back(fr(1, 0, 0, m_proc, 0));
    n = m_next();
    if (n != 0) begin
      q.push_back(fr(1, 1, m_tab[n], m_proc, 0));
      m_proc = 4'(n);
      m_cnt = 0;
      m_resume = m_tab[n];
      m_run = 1;
    end else begin
      q.push_back(fr(1, 1, 0, m_proc, 1));
      m_proc = '0;
      m_run = 0;
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_init();
    end else begin
      if (!cur.sw) begin
        if (!m_run) begin
          go = enable && (m_mask != 0);
          if (mask_load) m_mask = mask_data;
          if (go) m_pick();
        end else begin
          trig = 0;
          if (bus.instr_retire) begin
            m_cnt++;
            m_resume = bus.pc_atual + 1;
            if (bus.proc_end) begin
              m_mask &= ~(NP'(1) << (int'(m_proc) - 1));
              trig = 1;
            end
            if (m_cnt == QT) trig = 1;
          end
          if (!enable) trig = 1;
          if (trig) begin
            q.push_back(fr(1, 0, 0, m_proc, 0));
            m_tab[m_proc] = m_resume;
            if (enable) m_pick();
            else m_run = 0;
          end
        end
      end
      if (q.size() != 0) cur = q.pop_front();
      else cur = fr(0, 0, 0, m_proc, 0);
    end
  end

  always @(negedge clock) begin
    if (chk_on && reset) begin
      total++;
      if (bus.switch_req !== cur.sw ||
          bus.pc_load_valid !== cur.plv ||
          bus.pc_load_val !== cur.val ||
          processo_atual !== cur.pr ||
          all_done !== cur.ad) begin
        bad++;
        $display("FAIL cycle t=%0t got sw=%b plv=%b val=%0d proc=%0d done=%b want sw=%b plv=%b val=%0d proc=%0d done=%b",
                 $time, bus.switch_req, bus.pc_load_valid,
                 bus.pc_load_val, processo_atual, all_done,
                 cur.sw, cur.plv, cur.val, cur.pr, cur.ad);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quantum(input logic [31:0] base,
                         input int n, input bit end_last);
    for (int i = 0; i < n; i++) begin
      bus.instr_retire = 1'b1;
      bus.pc_atual = base + 32'(i);
      bus.proc_end = end_last && (i == n - 1);
      tick();
    end
    bus.instr_retire = 1'b0;
    bus.proc_end = 1'b0;
  endtask

  // called in the SAVE cycle right after the triggering retire
  task automatic after_switch(input string nm,
                              input logic [31:0] v,
                              input logic [3:0] p,
                              input bit ad);
    chk({nm, "_save_sw"}, 32'(bus.switch_req), 1);
    chk({nm, "_t1_plv"}, 32'(bus.pc_load_valid), 0);
    tick();
    chk({nm, "_t2_plv"}, 32'(bus.pc_load_valid), 0);
    tick();
    chk({nm, "_t3_plv"}, 32'(bus.pc_load_valid), 1);
    chk({nm, "_val"}, bus.pc_load_val, v);
    chk({nm, "_done"}, 32'(all_done), 32'(ad));
    tick();
    chk({nm, "_proc"}, 32'(processo_atual), 32'(p));
    chk({nm, "_sw_after"}, 32'(bus.switch_req), 0);
  endtask

  task automatic wait_load(input string nm);
    for (int i = 0; i < 10 && !bus.pc_load_valid; i++)
      tick();
    chk({nm, "_seen"}, 32'(bus.pc_load_valid), 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_sw"}, 32'(bus.switch_req), 0);
    chk({nm, "_plv"}, 32'(bus.pc_load_valid), 0);
    chk({nm, "_val"}, bus.pc_load_val, 0);
    chk({nm, "_proc"}, 32'(processo_atual), 0);
    chk({nm, "_done"}, 32'(all_done), 0);
  endtask

  initial begin
    m_init();
    bus.instr_retire = 1'b0;
    bus.pc_atual = '0;
    bus.proc_end = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outs("rst");
    reset = 1'b1;
    chk_on = 1;
    tick();

    // 1: processes 1 and 3 ready, start from OS
    mask_data = NP'(10'b0000000101);
    mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    enable = 1'b1;
    wait_load("t1");
    chk("t1_val", bus.pc_load_val, 300);
    tick();
    chk("t1_proc", 32'(processo_atual), 1);
    chk("t1_run_sw", 32'(bus.switch_req), 0);

    // 2: quantum in process 1 -> process 3
    quantum(300, 4, 0);
    after_switch("t2", 900, 3, 0);

    // 3: wrap back to process 1 with restored PC
    quantum(900, 4, 0);
    after_switch("t3", 304, 1, 0);

    // 4: proc_end on quantum expiry in process 3
    quantum(304, 4, 0);
    after_switch("t4a", 904, 3, 0);
    quantum(904, 4, 1);
    after_switch("t4b", 308, 1, 0);
    quantum(308, 4, 0);
    after_switch("t4c", 312, 1, 0);

    // 5: last process ends -> back to OS
    quantum(312, 1, 1);
    after_switch("t5", 0, 0, 1);
    chk("t5_done_once", 32'(all_done), 0);
    quantum(999, 1, 0);
    tick();
    chk("t5_idle_sw", 32'(bus.switch_req), 0);
    chk("t5_idle_proc", 32'(processo_atual), 0);

    // 6: mask ignored in RUN, reset during LOAD
    mask_data = NP'(10'b0000000011);
    mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    wait_load("t6a");
    chk("t6a_val", bus.pc_load_val, 313);
    tick();
    mask_data = '0;
    mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    quantum(313, 4, 0);
    after_switch("t6b", 600, 2, 0);
    quantum(600, 4, 0);
    tick();
    tick();
    chk("t6_in_load", 32'(bus.pc_load_valid), 1);
    reset = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    tick();
    reset = 1'b1;
    tick();
    mask_data = NP'(10'b0000000001);
    mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    wait_load("t6c");
    chk("t6c_tab_reset", bus.pc_load_val, 300);
    tick();
    chk("t6c_proc", 32'(processo_atual), 1);

    // 7: enable drop -> SAVE -> IDLE, then resume
    quantum(300, 1, 0);
    enable = 1'b0;
    tick();
    chk("t7_save_sw", 32'(bus.switch_req), 1);
    tick();
    chk("t7_idle_sw", 32'(bus.switch_req), 0);
    chk("t7_idle_proc", 32'(processo_atual), 1);
    enable = 1'b1;
    wait_load("t7");
    chk("t7_val", bus.pc_load_val, 301);
    tick();
    chk("t7_proc", 32'(processo_atual), 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
